ch4_noise_gen: RTL and testbench

- Channel 4 noise generator. Sits directly downstream of the channel 4 register block.
- Consumes the NR43 (FF22) fields (ratio, width, shift) plus the channel restart and enable.
- Frequency divider and prescaler produce LFSR shift pulses; a 15/7-bit LFSR produces the noise bit that feeds the channel 4 envelope/DAC stage.

---
 rtl/apu_ch4_pkg.sv | 20 ++
 rtl/ch4_lfsr.sv | 47 ++++
 rtl/ch4_noise_gen.sv | 98 +++++++++
 tb/tb_ch4_noise_gen.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apu_ch4_pkg.sv
// Shared definitions for the channel 4 noise path: LFSR seed, shift-code
// limit, the NR43 (FF22) field bundle and the divider period rule.
package apu_ch4_pkg;

  localparam logic [14:0]  LFSR_INIT = 15'h7FFF;
  localparam int unsigned  SHIFT_MAX = 13;

  typedef struct packed {
    logic [3:0] shift;
    logic       width;
    logic [2:0] ratio;
  } ff22_t;

  // Divider period in tick_1m pulses: r==0 behaves as a half step (1 tick).
  function automatic logic [3:0] div_period(input logic [2:0] ratio);
    if (ratio == 3'd0) return 4'd1;
    return {ratio, 1'b0};
  endfunction

endpackage

// File: rtl/ch4_lfsr.sv
// Channel 4 LFSR: 15-bit register with optional 7-bit tap, restart seed and,
// when CH4_LFSR_DEBUG_EN is defined, a direct load path and state visibility.
module ch4_lfsr
  import apu_ch4_pkg::*;
#(
  parameter int unsigned LFSR_W = 15
) (
  input  logic              i_clk,
  input  logic              i_napu_reset,
  input  logic              i_restart,
  input  logic              i_shift,
  input  logic              i_width,
`ifdef CH4_LFSR_DEBUG_EN
  input  logic              i_dbg_load,
  input  logic [LFSR_W-1:0] i_dbg_val,
  output logic [LFSR_W-1:0] o_lfsr,
`endif
  output logic              o_noise
);

  logic [LFSR_W-1:0] r_lfsr;
  logic [LFSR_W-1:0] w_next;
  logic              w_fb;

  // Next-state: XOR of the two low bits enters at the top, and also at bit 6 in 7-bit mode.
  always_comb begin
    w_fb   = r_lfsr[0] ^ r_lfsr[1];
    w_next = {w_fb, r_lfsr[LFSR_W-1:1]};
    if (i_width) w_next[6] = w_fb;
  end

  // LFSR register: debug load beats restart, restart beats a shift.
  always_ff @(posedge i_clk or negedge i_napu_reset) begin
    if (!i_napu_reset)    r_lfsr <= LFSR_W'(LFSR_INIT);
`ifdef CH4_LFSR_DEBUG_EN
    else if (i_dbg_load)  r_lfsr <= i_dbg_val;
`endif
    else if (i_restart)   r_lfsr <= LFSR_W'(LFSR_INIT);
    else if (i_shift)     r_lfsr <= w_next;
  end

  assign o_noise = ~r_lfsr[0];
`ifdef CH4_LFSR_DEBUG_EN
  assign o_lfsr  = r_lfsr;
`endif

endmodule

// File: rtl/ch4_noise_gen.sv
// Channel 4 noise generator: tick_1m divider, prescaler and LFSR shift
// pulse generation. Optional macro CH4_LFSR_DEBUG_EN exposes the LFSR state
// (lfsr_q) and a debug load port (dbg_load/dbg_val).
module ch4_noise_gen
  import apu_ch4_pkg::*;
#(
  parameter int unsigned LFSR_W = 15,
  parameter int unsigned PRE_W  = 14,
  parameter int unsigned DIV_W  = 4
) (
  input  logic              clk,
  input  logic              napu_reset,
  input  logic              tick_1m,
  input  logic              ch4_restart,
  input  logic              ch4_active,
  input  logic [2:0]        ff22_ratio,
  input  logic              ff22_width,
  input  logic [3:0]        ff22_shift,
`ifdef CH4_LFSR_DEBUG_EN
  output logic [LFSR_W-1:0] lfsr_q,
  input  logic              dbg_load,
  input  logic [LFSR_W-1:0] dbg_val,
`endif
  output logic              shift_pulse,
  output logic              noise_bit
);

  ff22_t             w_ff22;
  logic [DIV_W-1:0]  r_div;
  logic [PRE_W-1:0]  r_pre;
  logic              r_shift_pulse;
  logic [DIV_W-1:0]  w_reload;
  logic [31:0]       w_shift_code;
  logic              w_step;
  logic              w_div_exp;
  logic              w_code_ok;
  logic              w_pre_ones;
  logic              w_shift;

  assign w_ff22       = '{shift: ff22_shift, width: ff22_width, ratio: ff22_ratio};
  assign w_reload     = DIV_W'(div_period(w_ff22.ratio) - 4'd1);
  assign w_shift_code = 32'(w_ff22.shift);
  assign w_step       = tick_1m & ch4_active & ~ch4_restart;
  assign w_div_exp    = w_step & (r_div == '0);
  assign w_code_ok    = (w_shift_code <= SHIFT_MAX) && (w_shift_code < PRE_W);

  // Shift request: prescaler bits [s:0] all ones just before this expiry's increment.
  always_comb begin
    w_pre_ones = 1'b1;
    for (int unsigned i = 0; i < PRE_W; i++) begin
      if (i <= w_shift_code) w_pre_ones = w_pre_ones & r_pre[i];
    end
  end

  assign w_shift = w_div_exp & w_code_ok & w_pre_ones;

  // Divider/prescaler state and registered shift pulse; the period is only sampled at reload.
  always_ff @(posedge clk or negedge napu_reset) begin
    if (!napu_reset) begin
      r_div         <= '0;
      r_pre         <= '0;
      r_shift_pulse <= 1'b0;
    end else if (ch4_restart) begin
      r_div         <= w_reload;
      r_pre         <= '0;
      r_shift_pulse <= 1'b0;
    end else begin
      r_shift_pulse <= w_shift;
      if (w_step) begin
        if (r_div == '0) begin
          r_div <= w_reload;
          r_pre <= r_pre + PRE_W'(1);
        end else begin
          r_div <= r_div - DIV_W'(1);
        end
      end
    end
  end

  assign shift_pulse = r_shift_pulse;

  ch4_lfsr #(
    .LFSR_W (LFSR_W)
  ) u_lfsr (
    .i_clk        (clk),
    .i_napu_reset (napu_reset),
    .i_restart    (ch4_restart),
    .i_shift      (w_shift),
    .i_width      (w_ff22.width),
`ifdef CH4_LFSR_DEBUG_EN
    .i_dbg_load   (dbg_load),
    .i_dbg_val    (dbg_val),
    .o_lfsr       (lfsr_q),
`endif
    .o_noise      (noise_bit)
  );

endmodule

// File: tb/tb_ch4_noise_gen.sv
// Self-checking bench for ch4_noise_gen: directed scenarios plus a random
// phase, every cycle compared against a tick/expiry-count reference model.
module tb_ch4_noise_gen;

  logic        clk = 1'b0;
  logic        napu_reset;
  logic        tick_1m;
  logic        ch4_restart;
  logic        ch4_active;
  logic [2:0]  ff22_ratio;
  logic        ff22_width;
  logic [3:0]  ff22_shift;
  logic        shift_pulse;
  logic        noise_bit;
`ifdef CH4_LFSR_DEBUG_EN
  logic [14:0] lfsr_q;
  logic        dbg_load;
  logic [14:0] dbg_val;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state: ticks left until next expiry, expiries since restart, LFSR.
  int          m_wait;
  int          m_exp;
  logic [14:0] m_lfsr;
  logic        m_pulse;

  ch4_noise_gen #(
    .LFSR_W (15),
    .PRE_W  (14),
    .DIV_W  (4)
  ) dut (
    .clk         (clk),
    .napu_reset  (napu_reset),
    .tick_1m     (tick_1m),
    .ch4_restart (ch4_restart),
    .ch4_active  (ch4_active),
    .ff22_ratio  (ff22_ratio),
    .ff22_width  (ff22_width),
    .ff22_shift  (ff22_shift),
`ifdef CH4_LFSR_DEBUG_EN
    .lfsr_q      (lfsr_q),
    .dbg_load    (dbg_load),
    .dbg_val     (dbg_val),
`endif
    .shift_pulse (shift_pulse),
    .noise_bit   (noise_bit)
  );

  always #5 clk = ~clk;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int period(input logic [2:0] r);
    return (r == 3'd0) ? 1 : 2 * int'(r);
  endfunction

  function automatic logic [14:0] lfsr_next(input logic [14:0] l, input logic w);
    int v;
    int x;
    v = int'(l);
    x = (v ^ (v >> 1)) & 1;
    v = (v >> 1) | (x << 14);
    if (w) v = (v & ~(1 << 6)) | (x << 6);
    return v[14:0];
  endfunction

  task automatic model_reset();
    m_wait  = 1;
    m_exp   = 0;
    m_lfsr  = 15'h7FFF;
    m_pulse = 1'b0;
  endtask

  task automatic model_edge();
    int span;
    m_pulse = 1'b0;
    if (!napu_reset) begin
      model_reset();
      return;
    end
    if (ch4_restart) begin
      m_wait = period(ff22_ratio);
      m_exp  = 0;
      m_lfsr = 15'h7FFF;
    end else if (tick_1m && ch4_active) begin
      m_wait--;
      if (m_wait == 0) begin
        m_wait = period(ff22_ratio);
        if (int'(ff22_shift) <= 13) begin
          span = 1 << (int'(ff22_shift) + 1);
          if ((m_exp % span) == span - 1) begin
            m_lfsr  = lfsr_next(m_lfsr, ff22_width);
            m_pulse = 1'b1;
          end
        end
        m_exp = (m_exp + 1) % 16384;
      end
    end
`ifdef CH4_LFSR_DEBUG_EN
    if (dbg_load) m_lfsr = dbg_val;
`endif
  endtask

  task automatic step();
    logic e_noise;
    @(posedge clk);
    model_edge();
    #1;
    e_noise = ~m_lfsr[0];
    chk("shift_pulse", {31'b0, shift_pulse}, {31'b0, m_pulse});
    chk("noise_bit", {31'b0, noise_bit}, {31'b0, e_noise});
`ifdef CH4_LFSR_DEBUG_EN
    chk("lfsr_q", {17'b0, lfsr_q}, {17'b0, m_lfsr});
`endif
  endtask

  task automatic restart();
    ch4_restart = 1'b1;
    step();
    ch4_restart = 1'b0;
  endtask

  task automatic run_until_pulse(input int bound, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!shift_pulse && n < bound);
  endtask

  task automatic run_count(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (shift_pulse) pulses++;
    end
  endtask

  initial begin
    int n;
    int np;
    int steps;
    logic noise_seen;

    napu_reset  = 1'b0;
    tick_1m     = 1'b0;
    ch4_restart = 1'b0;
    ch4_active  = 1'b0;
    ff22_ratio  = 3'd0;
    ff22_width  = 1'b0;
    ff22_shift  = 4'd0;
`ifdef CH4_LFSR_DEBUG_EN
    dbg_load    = 1'b0;
    dbg_val     = '0;
`endif
    model_reset();

    // Reset held
    for (int i = 0; i < 3; i++) step();
    chk("reset_pulse", {31'b0, shift_pulse}, 32'd0);
    chk("reset_noise", {31'b0, noise_bit}, 32'd0);
    napu_reset = 1'b1;
    tick_1m    = 1'b1;
    ch4_active = 1'b1;

    // r=0 s=0 width=0: shift every 2 ticks, first '1' noise after 15 shifts
    restart();
    run_until_pulse(5, n);
    chk("first_pulse_at", n, 32'd2);
`ifdef CH4_LFSR_DEBUG_EN
    chk("first_shift_lfsr", {17'b0, lfsr_q}, 32'h3FFF);
`endif
    chk("first_shift_noise", {31'b0, noise_bit}, 32'd0);
    run_until_pulse(5, n);
    chk("pulse_gap_r0s0", n, 32'd2);
    np = 2;
    noise_seen = 1'b0;
    steps = 0;
    while (!noise_seen && steps < 60) begin
      step();
      steps++;
      if (shift_pulse) np++;
      if (noise_bit) noise_seen = 1'b1;
    end
    chk("shifts_to_first_one", np, 32'd15);

    // Full 15-bit period
    restart();
    np = 0;
    steps = 0;
    while (np < 32767 && steps < 70000) begin
      step();
      steps++;
      if (shift_pulse) np++;
    end
    chk("full_period_steps", steps, 32'd65534);
`ifdef CH4_LFSR_DEBUG_EN
    chk("full_period_lfsr", {17'b0, lfsr_q}, 32'h7FFF);
`endif

    // 7-bit mode
    ff22_width = 1'b1;
    restart();
    run_until_pulse(5, n);
    chk("w7_first_pulse_at", n, 32'd2);
`ifdef CH4_LFSR_DEBUG_EN
    chk("w7_first_shift_lfsr", {17'b0, lfsr_q}, 32'h3FBF);
`endif
    run_count(300, np);
    chk("w7_pulses_300", np, 32'd150);
    ff22_width = 1'b0;
    run_count(40, np);

    // r=3 s=2: 48-tick interval, ratio change waits for the running reload
    ff22_ratio = 3'd3;
    ff22_shift = 4'd2;
    restart();
    run_until_pulse(60, n);
    chk("r3s2_first", n, 32'd48);
    run_until_pulse(60, n);
    chk("r3s2_interval", n, 32'd48);
    for (int i = 0; i < 3; i++) step();
    ff22_ratio = 3'd1;
    run_until_pulse(60, n);
    chk("r_change_interval", n + 3, 32'd20);
    run_until_pulse(60, n);
    chk("r1s2_interval", n, 32'd16);

    // Shift codes 14 and 15: no shifts, prescaler still runs
    ff22_ratio = 3'd0;
    ff22_shift = 4'd14;
    restart();
    run_count(1500, np);
    chk("s14_pulses", np, 32'd0);
    ff22_shift = 4'd15;
    run_count(1500, np);
    chk("s15_pulses", np, 32'd0);
    chk("s15_noise", {31'b0, noise_bit}, 32'd0);
    ff22_shift = 4'd0;
    run_until_pulse(10, n);
    chk("s0_resume", {31'b0, shift_pulse}, 32'd1);

    // Restart coincident with a shift-producing tick
    restart();
    step();
    restart();
    chk("restart_beats_shift", {31'b0, shift_pulse}, 32'd0);
    run_until_pulse(5, n);
    chk("after_restart_full", n, 32'd2);

    // Inactive channel freezes everything
    ch4_active = 1'b0;
    run_count(50, np);
    chk("inactive_pulses", np, 32'd0);
    ch4_active = 1'b1;
    run_until_pulse(5, n);
    chk("active_resume", n, 32'd2);

    // Random phase
    for (int i = 0; i < 3000; i++) begin
      tick_1m     = ($urandom % 4) != 0;
      ch4_active  = ($urandom % 16) != 0;
      ch4_restart = ($urandom % 200) == 0;
      if ($urandom % 100 == 0) ff22_ratio = 3'($urandom % 8);
      if ($urandom % 100 == 0)
        ff22_shift = ($urandom % 8 == 0) ? 4'(14 + $urandom % 2) : 4'($urandom % 4);
      if ($urandom % 150 == 0) ff22_width = ~ff22_width;
      step();
    end
    tick_1m     = 1'b1;
    ch4_active  = 1'b1;
    ch4_restart = 1'b0;
    ff22_ratio  = 3'd0;
    ff22_shift  = 4'd0;
    ff22_width  = 1'b0;

    // Asynchronous reset between clock edges
    restart();
    steps = 0;
    while (!noise_bit && steps < 100) begin
      step();
      steps++;
    end
    chk("noise_high_before_reset", {31'b0, noise_bit}, 32'd1);
    #3;
    napu_reset = 1'b0;
    model_reset();
    #1;
    chk("async_reset_noise", {31'b0, noise_bit}, 32'd0);
    chk("async_reset_pulse", {31'b0, shift_pulse}, 32'd0);
`ifdef CH4_LFSR_DEBUG_EN
    chk("async_reset_lfsr", {17'b0, lfsr_q}, 32'h7FFF);
`endif
    step();
    step();
    napu_reset = 1'b1;
    run_count(20, np);
    chk("post_reset_pulses", np, 32'd10);

`ifdef CH4_LFSR_DEBUG_EN
    // Debug load then a shift; load wins over a coincident restart
    dbg_load = 1'b1;
    dbg_val  = 15'h0001;
    step();
    dbg_load = 1'b0;
    chk("dbg_load_val", {17'b0, lfsr_q}, 32'h0001);
    run_until_pulse(5, n);
    chk("dbg_shift_lfsr", {17'b0, lfsr_q}, 32'h4000);
    dbg_load    = 1'b1;
    dbg_val     = 15'h1234;
    ch4_restart = 1'b1;
    step();
    dbg_load    = 1'b0;
    ch4_restart = 1'b0;
    chk("dbg_over_restart", {17'b0, lfsr_q}, 32'h1234);
    run_count(10, np);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
